// File: rtl/i2c_path_arb_pkg.sv
// i2c_path_arb_pkg: shared path indices, pad bit positions, FSM states and path-to-pad helpers
package i2c_path_arb_pkg;
    localparam int NPATH = 5;
    localparam logic [2:0] PATH_SCL  = 3'd0;
    localparam logic [2:0] PATH_CC21 = 3'd1;
    localparam logic [2:0] PATH_CC12 = 3'd2;
    localparam logic [2:0] PATH_DNDP = 3'd3;
    localparam logic [2:0] PATH_DPDN = 3'd4;
    localparam logic [2:0] PATH_NONE = 3'd7;
    localparam logic [2:0] PAD_SCL = 3'd0;
    localparam logic [2:0] PAD_SDA = 3'd1;
    localparam logic [2:0] PAD_CC1 = 3'd2;
    localparam logic [2:0] PAD_CC2 = 3'd3;
    localparam logic [2:0] PAD_DP  = 3'd4;
    localparam logic [2:0] PAD_DN  = 3'd5;
    typedef enum logic [1:0] {ST_HUNT = 2'd0, ST_LOCK = 2'd1, ST_HOLD = 2'd2} state_t;
    function automatic logic [2:0] sck_pad(input logic [2:0] p);
        return p == PATH_CC21 ? PAD_CC2 : p == PATH_CC12 ? PAD_CC1 :
               p == PATH_DNDP ? PAD_DN  : p == PATH_DPDN ? PAD_DP  : PAD_SCL;
    endfunction
    function automatic logic [2:0] sda_pad(input logic [2:0] p);
        return p == PATH_CC21 ? PAD_CC1 : p == PATH_CC12 ? PAD_CC2 :
               p == PATH_DNDP ? PAD_DP  : p == PATH_DPDN ? PAD_DN  : PAD_SDA;
    endfunction
    function automatic logic [2:0] first_set(input logic [4:0] m);
        return m[0] ? PATH_SCL : m[1] ? PATH_CC21 : m[2] ? PATH_CC12 :
               m[3] ? PATH_DNDP : m[4] ? PATH_DPDN : PATH_NONE;
    endfunction
endpackage

// File: rtl/i2c_path_arb_cond.sv
// i2c_cond_det: START/STOP/SCK-edge detect for one SCK/SDA pair of synchronised pad bits
//  i_sck_s2/i_sck_s3  current and previous synchronised SCK
//  i_sda_s2/i_sda_s3  current and previous synchronised SDA
//  o_start/o_stop     SDA fall/rise while SCK stable high
//  o_sck_edge         SCK changed this cycle
module i2c_cond_det (
    input  logic i_sck_s2,
    input  logic i_sck_s3,
    input  logic i_sda_s2,
    input  logic i_sda_s3,
    output logic o_start,
    output logic o_stop,
    output logic o_sck_edge
);
    assign o_start    = i_sck_s3 & i_sck_s2 & i_sda_s3 & ~i_sda_s2;
    assign o_stop     = i_sck_s3 & i_sck_s2 & ~i_sda_s3 & i_sda_s2;
    assign o_sck_edge = i_sck_s3 ^ i_sck_s2;
endmodule

// File: rtl/i2c_path_arb.sv
// i2c_path_arb: locks the debug I2C slave onto whichever pad pair shows a START first
//  clk, rstz          core clock, async active-low reset
//  r_en, r_fix, r_fix_path  path enable mask, forced-lock control
//  i_pad, i_sda_low   raw pads {dn,dp,cc2,cc1,sda,scl}, slave SDA pull-down request
//  o_scl, o_sda       registered bus to slave
//  o_pad_oe           open-drain low enables onto the locked SDA pad
//  o_cci2c_en, o_ddi2c_en  CC / DP-DN receiver enables
//  o_lock, o_path, o_switch  lock status, locked path (7 = none), new-lock pulse
module i2c_path_arb
    import i2c_path_arb_pkg::*;
#(
    parameter int TOUT_CYC = 20000,
    parameter int HOLD_CYC = 1200,
    parameter int CNT_W    = 15
) (
    input  logic       clk,
    input  logic       rstz,
    input  logic [4:0] r_en,
    input  logic       r_fix,
    input  logic [2:0] r_fix_path,
    input  logic [5:0] i_pad,
    input  logic       i_sda_low,
    output logic       o_scl,
    output logic       o_sda,
    output logic [5:0] o_pad_oe,
    output logic       o_cci2c_en,
    output logic       o_ddi2c_en,
    output logic       o_lock,
    output logic [2:0] o_path,
    output logic       o_switch
);
    logic [5:0]       r_s1, r_s2, r_s3;
    logic [4:0]       w_start, w_stop, w_edge;
    state_t           r_state, w_state;
    logic [2:0]       r_path, w_path, r_fix_path_q;
    logic [CNT_W-1:0] r_cnt, w_cnt, w_cnt_inc;
    logic [5:0]       r_pad_oe;
    logic             r_scl, r_sda, r_switch, w_switch, r_fix_q, w_fix_ok, w_fix_new;

    for (genvar i = 0; i < NPATH; i++) begin : g_det
        i2c_cond_det u_det (
            .i_sck_s2  (r_s2[sck_pad(3'(i))]),
            .i_sck_s3  (r_s3[sck_pad(3'(i))]),
            .i_sda_s2  (r_s2[sda_pad(3'(i))]),
            .i_sda_s3  (r_s3[sda_pad(3'(i))]),
            .o_start   (w_start[i]),
            .o_stop    (w_stop[i]),
            .o_sck_edge(w_edge[i])
        );
    end

    assign w_fix_ok  = r_fix_path < 3'(NPATH);
    assign w_fix_new = !r_fix_q || r_fix_path != r_fix_path_q;
    assign w_cnt_inc = r_cnt + {{(CNT_W-1){1'b0}}, ~&r_cnt};

    // Data and pad-enable registers load from the next path so the slave sees
    // SDA fall with SCK high on the very cycle the lock is taken.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            {r_s1, r_s2, r_s3} <= '1;
            r_state      <= ST_HUNT;
            r_path       <= PATH_NONE;
            r_cnt        <= '0;
            r_scl        <= 1'b1;
            r_sda        <= 1'b1;
            r_pad_oe     <= '0;
            r_switch     <= 1'b0;
            r_fix_q      <= 1'b0;
            r_fix_path_q <= PATH_NONE;
        end else begin
            r_s1         <= i_pad;
            r_s2         <= r_s1;
            r_s3         <= r_s2;
            r_state      <= w_state;
            r_path       <= w_path;
            r_cnt        <= w_cnt;
            r_scl        <= w_state == ST_HUNT || r_s2[sck_pad(w_path)];
            r_sda        <= w_state == ST_HUNT || r_s2[sda_pad(w_path)];
            r_pad_oe     <= w_state == ST_HUNT ? 6'd0 : 6'(i_sda_low) << sda_pad(w_path);
            r_switch     <= w_switch;
            r_fix_q      <= r_fix;
            r_fix_path_q <= r_fix_path;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_path   = r_path;
        w_cnt    = r_cnt;
        w_switch = 1'b0;
        if (r_fix) begin
            w_state  = w_fix_ok ? ST_LOCK : ST_HUNT;
            w_path   = w_fix_ok ? r_fix_path : PATH_NONE;
            w_switch = w_fix_ok && w_fix_new;
        end else if (r_fix_q || (r_state != ST_HUNT && !r_en[r_path])) begin
            w_state = ST_HUNT;
            w_path  = PATH_NONE;
            w_cnt   = '0;
        end else if (r_state == ST_HUNT) begin
            w_cnt = '0;
            if (|(w_start & r_en)) begin
                w_state  = ST_LOCK;
                w_path   = first_set(w_start & r_en);
                w_switch = 1'b1;
            end
        end else if (r_state == ST_LOCK) begin
            w_cnt = w_edge[r_path] ? '0 : w_cnt_inc;
            if (w_stop[r_path]) begin
                w_state = ST_HOLD;
                w_cnt   = '0;
            end else if (r_cnt == CNT_W'(TOUT_CYC - 1)) begin
                w_state = ST_HUNT;
                w_path  = PATH_NONE;
                w_cnt   = '0;
            end
        end else begin
            w_cnt = w_cnt_inc;
            if (w_start[r_path]) begin
                w_state = ST_LOCK;
                w_cnt   = '0;
            end else if (r_cnt == CNT_W'(HOLD_CYC - 1)) begin
                w_state = ST_HUNT;
                w_path  = PATH_NONE;
                w_cnt   = '0;
            end
        end
    end

    always_comb begin
        o_lock     = r_state != ST_HUNT;
        o_path     = r_path;
        o_scl      = r_scl;
        o_sda      = r_sda;
        o_pad_oe   = r_pad_oe;
        o_switch   = r_switch;
        o_cci2c_en = r_state != ST_HUNT ? (r_path == PATH_CC21 || r_path == PATH_CC12) : |r_en[2:1];
        o_ddi2c_en = r_state != ST_HUNT ? (r_path == PATH_DNDP || r_path == PATH_DPDN) : |r_en[4:3];
    end
endmodule
